// File: rtl/helloworld_checker.sv
// helloworld_checker: walks a/b/c through vectors 0..7, compares y against EXPECTED, reports pass/fail.
// Optional per-vector capture of y on the observed port when HELLOWORLD_CHECKER_OBSERVE_EN is defined.
`timescale 1ns/1ps
module helloworld_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter logic [7:0] EXPECTED = 8'hE8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail_vec,
    output logic [7:0] observed
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t state_q, state_d;
    logic [2:0] vec_q, vec_d, ffv_q, ffv_d;
    logic [3:0] cnt_q, cnt_d, fail_q, fail_d;
    logic pass_q, pass_d, miss, go;
    assign go = state_q == IDLE && start;
    assign miss = y != EXPECTED[vec_q];
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: if (start) begin
                vec_d   = 3'd0;
                fail_d  = 4'd0;
                ffv_d   = 3'd0;
                pass_d  = 1'b0;
                cnt_d   = 4'(SETTLE_CYCLES);
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                // first_fail_vec only latches while the run is still clean
                fail_d = miss ? fail_q + 4'd1 : fail_q;
                ffv_d  = miss && fail_q == 4'd0 ? vec_q : ffv_q;
                if (vec_q == 3'd7) begin
                    pass_d  = fail_d == 4'd0;
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = 4'(SETTLE_CYCLES);
                    state_d = SETTLE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= 4'd0;
            fail_q  <= 4'd0;
            ffv_q   <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end
    assign {a, b, c}      = vec_q;
    assign busy           = state_q == SETTLE || state_q == SAMPLE;
    assign done           = state_q == DONE;
    assign pass           = pass_q;
    assign fail_count     = fail_q;
    assign first_fail_vec = ffv_q;
`ifdef HELLOWORLD_CHECKER_OBSERVE_EN
    logic [7:0] obs_q, obs_d;
    always_comb begin
        obs_d = go ? 8'h00 : obs_q;
        if (state_q == SAMPLE) obs_d[vec_q] = y;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) obs_q <= 8'h00;
        else        obs_q <= obs_d;
    end
    assign observed = obs_q;
`else
    assign observed = 8'h00;
`endif
endmodule

// File: tb/tb_helloworld_checker.sv
// tb_helloworld_checker: cycle-accurate reference model plus directed runs for helloworld_checker.
`timescale 1ns/1ps
module tb_helloworld_checker;
    localparam int S = 2;
    localparam int P = S + 1;
    localparam int N = 8 * P;
    localparam logic [7:0] EXP = 8'hE8;

    logic clk = 0, rst_n = 0, start = 0, ymode = 0;
    logic a, b, c, y, busy, done, pass;
    logic [3:0] fail_count;
    logic [2:0] first_fail_vec;
    logic [7:0] observed;
    int checks = 0, passed = 0;

    always #5 clk = ~clk;

    // ymode 0: majority(a,b,c); ymode 1: stuck at 0
    assign y = ymode ? 1'b0 : ((32'(a) + 32'(b) + 32'(c)) >= 2);

    helloworld_checker #(.SETTLE_CYCLES(S), .EXPECTED(EXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y(y),
        .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_vec(first_fail_vec), .observed(observed)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit model_y(input int i, input bit m);
        return m ? 1'b0 : (((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1)) >= 2;
    endfunction

    // t = cycles since start was accepted (0 = idle); ran = a run has completed since reset
    int t;
    bit ran, rmode;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t   <= 0;
            ran <= 0;
        end else if (t == 0) begin
            if (start) begin
                t     <= 1;
                rmode <= ymode;
            end
        end else if (t == N + 1) begin
            t   <= 0;
            ran <= 1;
        end else t <= t + 1;
    end

    always @(negedge clk) begin
        int k, idx, nf, ff;
        logic [7:0] obs;
        k   = (t == 0) ? (ran ? 8 : 0) : (t - 1) / P;
        idx = (t == 0) ? (ran ? 7 : 0) : (t <= N ? (t - 1) / P : 7);
        nf = 0; ff = 0; obs = 8'h00;
        for (int i = 0; i < k; i++) begin
            obs[i] = model_y(i, rmode);
            if (model_y(i, rmode) != EXP[i]) begin
                if (nf == 0) ff = i;
                nf++;
            end
        end
        check("busy", int'(busy), int'(t >= 1 && t <= N));
        check("done", int'(done), int'(t == N + 1));
        check("abc", int'({a, b, c}), idx);
        check("fail_count", int'(fail_count), nf);
        check("first_fail_vec", int'(first_fail_vec), ff);
        check("pass", int'(pass), int'((t == N + 1 || (t == 0 && ran)) && nf == 0));
`ifdef HELLOWORLD_CHECKER_OBSERVE_EN
        check("observed", int'(observed), int'(obs));
`else
        check("observed", int'(observed), 0);
`endif
    end

    // Pulse start, then watch up to 60 cycles, counting busy/done and latching results at done.
    task automatic run(input int ign_at, output int bc, output int dc,
                       output logic p, output logic [3:0] fc, output logic [2:0] ff, output logic [7:0] ob);
        bc = 0; dc = 0; p = 0; fc = 0; ff = 0; ob = 0;
        start = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) bc++;
            start = (busy && bc == ign_at);
            if (done) begin
                dc++;
                p = pass; fc = fail_count; ff = first_fail_vec; ob = observed;
            end
        end
        start = 0;
    endtask

    int bc, dc;
    logic p;
    logic [3:0] fc;
    logic [2:0] ff;
    logic [7:0] ob, ob_exp;

    initial begin
`ifdef HELLOWORLD_CHECKER_OBSERVE_EN
        ob_exp = 8'hE8;
`else
        ob_exp = 8'h00;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_abc", int'({a, b, c}), 0);
        check("reset_fail", int'(fail_count), 0);

        run(0, bc, dc, p, fc, ff, ob);
        check("maj_busy_cycles", bc, 24);
        check("maj_done_pulses", dc, 1);
        check("maj_pass", int'(p), 1);
        check("maj_fail_count", int'(fc), 0);
        check("maj_observed", int'(ob), int'(ob_exp));
        check("maj_abc_hold", int'({a, b, c}), 7);

        ymode = 1;
        run(0, bc, dc, p, fc, ff, ob);
        check("stuck_pass", int'(p), 0);
        check("stuck_fail_count", int'(fc), 4);
        check("stuck_first_fail", int'(ff), 3);
        check("stuck_done_pulses", dc, 1);

        ymode = 0;
        run(5, bc, dc, p, fc, ff, ob);
        check("ign_busy_cycles", bc, 24);
        check("ign_done_pulses", dc, 1);
        check("ign_pass", int'(p), 1);

        start = 1;
        bc = 0;
        for (int i = 0; i < 40 && bc < 10; i++) begin
            @(negedge clk);
            start = 0;
            if (busy) bc++;
        end
        check("rst_reached_cycle10", bc, 10);
        #2 rst_n = 0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_abc", int'({a, b, c}), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_fail", int'(fail_count), 0);
        check("rst_ffv", int'(first_fail_vec), 0);
        check("rst_observed", int'(observed), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        run(0, bc, dc, p, fc, ff, ob);
        check("post_rst_busy_cycles", bc, 24);
        check("post_rst_done_pulses", dc, 1);
        check("post_rst_pass", int'(p), 1);
        check("post_rst_observed", int'(ob), int'(ob_exp));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
